// File: rtl/mem_pkg.sv
// Shared types for the mem_copy_dma block copy engine.
// Holds default widths, the engine state enum and the length type.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 11;
    localparam int MEM_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    typedef logic [MEM_ADDR_WIDTH:0] len_t;

endpackage

// File: rtl/addr_counter.sv
// Loadable word-address pointer for mem_copy_dma.
// Increments modulo 2**W, so the top address wraps to zero.
module addr_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_copy_dma.sv
// Ascending block copy engine driving a single-port async-read memory.
// Define MEM_COPY_DMA_FILL_EN to add the fill_mode/fill_value pattern fill.
module mem_copy_dma
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_read_data
`ifdef MEM_COPY_DMA_FILL_EN
    ,
    input  logic                  fill_mode,
    input  logic [DATA_WIDTH-1:0] fill_value
`endif
);

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  fill_q;
    logic                  fill_in;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  accept;
    logic                  last_word;

`ifdef MEM_COPY_DMA_FILL_EN
    assign fill_in   = fill_mode;
    assign fill_data = fill_value;
`else
    assign fill_in   = 1'b0;
    assign fill_data = '0;
`endif

    assign accept    = (state == IDLE) && start;
    assign last_word = (remaining == (ADDR_WIDTH+1)'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_nxt = DONE;
                    end else if (fill_in) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: state_nxt = WRITE;
            WRITE: begin
                if (last_word) begin
                    state_nxt = DONE;
                end else if (fill_q) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = READ;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    addr_counter #(.W(ADDR_WIDTH)) u_src_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .inc        (state == WRITE),
        .load_value (src_addr),
        .count      (src_ptr)
    );

    addr_counter #(.W(ADDR_WIDTH)) u_dst_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .inc        (state == WRITE),
        .load_value (dst_addr),
        .count      (dst_ptr)
    );

    // In fill mode data_reg holds the pattern and is never reloaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= '0;
            data_reg  <= '0;
            fill_q    <= 1'b0;
        end else if (accept) begin
            remaining <= length;
            data_reg  <= fill_data;
            fill_q    <= fill_in;
        end else if (state == READ) begin
            data_reg  <= mem_read_data;
        end else if (state == WRITE) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign busy         = (state == READ) || (state == WRITE);
    assign done         = (state == DONE);
    assign mem_write_en = (state == WRITE);
    assign mem_data_out = (state == WRITE) ? data_reg : '0;

    always_comb begin
        mem_address = '0;
        if (state == READ) begin
            mem_address = src_ptr;
        end else if (state == WRITE) begin
            mem_address = dst_ptr;
        end
    end

endmodule
